// File: rtl/stage_fetch1_pkg.sv
// +-----------------------------------------------------------------------------+
// | stage_fetch1_pkg : shared types and constants for the fetch1 stage          |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

package stage_fetch1_pkg;

  localparam int FE1_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] insn;
    logic        exc;
    logic        done;
  } fe1_entry_t;

endpackage

`default_nettype wire

// File: rtl/stage_fetch1_fetch_queue.sv
// +-----------------------------------------------------------------------------+
// | fetch_queue : in-order fetch queue with head / fill / tail pointers, flush  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fetch_queue
  import stage_fetch1_pkg::*;
#(
  parameter int DEPTH = FE1_DEPTH_DEFAULT,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_core,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [29:0]       push_pc,
  input  logic              fill,
  input  logic [31:0]       fill_insn,
  input  logic              fill_exc,
  input  logic              pop,
  output fe1_entry_t        head,
  output logic [PW:0]       count,
  output logic [PW:0]       unfilled
);

  fe1_entry_t      r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_fill;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;
  logic [PW:0]     r_unfilled;
  logic            w_fill;

  // A stray fill with nothing outstanding must not corrupt a completed entry.
  assign w_fill = fill & (r_unfilled != '0);

  always_ff @(posedge clk_core) begin
    if (!reset_n || flush) begin
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
    end else begin
      if (push)   r_tail <= r_tail + PW'(1);
      if (w_fill) r_fill <= r_fill + PW'(1);
      if (pop)    r_head <= r_head + PW'(1);
      r_count    <= r_count + (PW+1)'(push) - (PW+1)'(pop);
      r_unfilled <= r_unfilled + (PW+1)'(push) - (PW+1)'(w_fill);
    end
  end

  // Payload needs no reset: validity is carried by r_count and the done bit.
  always_ff @(posedge clk_core) begin
    if (push) begin
      r_mem[r_tail] <= '{pc: push_pc, insn: 32'h0, exc: 1'b0, done: 1'b0};
    end
    if (w_fill) begin
      r_mem[r_fill].insn <= fill_insn;
      r_mem[r_fill].exc  <= fill_exc;
      r_mem[r_fill].done <= 1'b1;
    end
  end

  assign head     = r_mem[r_head];
  assign count    = r_count;
  assign unfilled = r_unfilled;

endmodule

`default_nettype wire

// File: rtl/stage_fetch1.sv
// +-----------------------------------------------------------------------------+
// | stage_fetch1 : issues fetch0 PCs to imem, queues fetches, offers to decode  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module stage_fetch1
  import stage_fetch1_pkg::*;
#(
  parameter int DEPTH = FE1_DEPTH_DEFAULT
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        fe0_valid,
  input  logic [29:0] fe0_pc,
  output logic        fe1_stall,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rerr,
  input  logic        de_setpc,
  input  logic        de_stall,
  output logic        fe1_valid,
  output logic        fe1_exc,
  output logic [29:0] fe1_pc,
  output logic [31:0] fe1_insn
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW+1:0] c_depth = (PW+2)'(DEPTH);

  fe1_entry_t      w_head;
  logic [PW:0]     w_count;
  logic [PW:0]     w_unfilled;
  logic [PW:0]     r_drop_cnt;
  logic [PW+1:0]   w_occupancy;
  logic            w_accept;
  logic            w_consume;
  logic            w_fill;
  logic            w_head_live;
  logic            w_head_done;

  // Responses still owed for killed fetches occupy memory slots just like queue entries.
  assign w_occupancy = {1'b0, w_count} + {1'b0, r_drop_cnt};
  assign imem_req    = reset_n & fe0_valid & ~de_setpc & (w_occupancy < c_depth);
  assign imem_addr   = fe0_pc;
  assign w_accept    = imem_req & imem_gnt;
  assign fe1_stall   = fe0_valid & ~w_accept;

  assign w_fill      = imem_rvalid & (r_drop_cnt == '0) & ~de_setpc;

  assign w_head_live = (w_count != '0);
  assign w_head_done = w_head_live & w_head.done;
  assign fe1_valid   = w_head_done & ~de_setpc;
  assign w_consume   = fe1_valid & ~de_stall;
  assign fe1_exc     = w_head_done & w_head.exc;
  assign fe1_pc      = w_head_live ? w_head.pc : 30'h0;
  assign fe1_insn    = w_head_done ? w_head.insn : 32'h0;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_core  (clk_core),
    .reset_n   (reset_n),
    .flush     (de_setpc),
    .push      (w_accept),
    .push_pc   (fe0_pc),
    .fill      (w_fill),
    .fill_insn (imem_rerr ? 32'h0 : imem_rdata),
    .fill_exc  (imem_rerr),
    .pop       (w_consume),
    .head      (w_head),
    .count     (w_count),
    .unfilled  (w_unfilled)
  );

  // A response in the kill cycle is the oldest owed one, so it retires one debt either way.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (de_setpc) begin
      r_drop_cnt <= r_drop_cnt + w_unfilled - (PW+1)'(imem_rvalid);
    end else if (imem_rvalid && (r_drop_cnt != '0)) begin
      r_drop_cnt <= r_drop_cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset_n && imem_rvalid) begin
      assert ((r_drop_cnt != '0) || (w_unfilled != '0));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stage_fetch1.sv
// +-----------------------------------------------------------------------------+
// | tb_stage_fetch1 : scoreboard bench for stage_fetch1 with in-order imem model|
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_stage_fetch1;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] insn;
    logic        exc;
  } exp_t;

  localparam logic [29:0] c_fault_wa = 30'h0C0;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        fe0_valid;
  logic [29:0] fe0_pc;
  logic        fe1_stall;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_rerr;
  logic        de_setpc;
  logic        de_stall;
  logic        fe1_valid;
  logic        fe1_exc;
  logic [29:0] fe1_pc;
  logic [31:0] fe1_insn;

  logic [29:0] issue_q [$];
  logic [29:0] mem_q [$];
  exp_t        exp_q [$];
  logic        mem_en;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  logic        s_req, s_stall, s_valid, s_exc;
  logic [29:0] s_pc;
  logic [31:0] s_insn;
  logic [7:0]  s_count, s_drop;

  always #5 clk_core = ~clk_core;

  stage_fetch1 #(.DEPTH(2)) dut (
    .clk_core    (clk_core),
    .reset_n     (reset_n),
    .fe0_valid   (fe0_valid),
    .fe0_pc      (fe0_pc),
    .fe1_stall   (fe1_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_rerr   (imem_rerr),
    .de_setpc    (de_setpc),
    .de_stall    (de_stall),
    .fe1_valid   (fe1_valid),
    .fe1_exc     (fe1_exc),
    .fe1_pc      (fe1_pc),
    .fe1_insn    (fe1_insn)
  );

  function automatic logic [31:0] insn_of(input logic [29:0] wa);
    return {wa, 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, update models, advance.
  task automatic step();
    exp_t e;
    fe0_valid   = (issue_q.size() != 0);
    fe0_pc      = fe0_valid ? issue_q[0] : 30'h0;
    imem_rvalid = reset_n && mem_en && (mem_q.size() != 0);
    imem_rdata  = imem_rvalid ? insn_of(mem_q[0]) : 32'h0;
    imem_rerr   = imem_rvalid && (mem_q[0] == c_fault_wa);
    #1;
    s_req   = imem_req;
    s_stall = fe1_stall;
    s_valid = fe1_valid;
    s_exc   = fe1_exc;
    s_pc    = fe1_pc;
    s_insn  = fe1_insn;
    s_count = 8'(dut.w_count);
    s_drop  = 8'(dut.r_drop_cnt);
    if (!reset_n) begin
      mem_q.delete();
      exp_q.delete();
    end else begin
      if (imem_rvalid) void'(mem_q.pop_front());
      if (imem_req && imem_gnt) begin
        mem_q.push_back(imem_addr);
        e.pc   = fe0_pc;
        e.exc  = (fe0_pc == c_fault_wa);
        e.insn = e.exc ? 32'h0 : insn_of(fe0_pc);
        exp_q.push_back(e);
        void'(issue_q.pop_front());
      end
      if (fe1_valid && !de_stall) begin
        if (exp_q.size() == 0) begin
          check_value("unexpected_delivery_pc", 32'(fe1_pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_value("deliver_pc", 32'(fe1_pc), 32'(e.pc));
          check_value("deliver_insn", fe1_insn, e.insn);
          check_value("deliver_exc", 32'(fe1_exc), 32'(e.exc));
          n_deliv++;
        end
      end
      if (de_setpc) exp_q.delete();
    end
    @(negedge clk_core);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    imem_gnt = 1'b1;
    de_setpc = 1'b0;
    de_stall = 1'b0;
    mem_en   = 1'b0;
    @(negedge clk_core);
    step();
    step();
    reset_n = 1'b1;
    step();
    check_value("rst_valid", 32'(s_valid), 32'd0);
    check_value("rst_pc", 32'(s_pc), 32'd0);
    check_value("rst_insn", s_insn, 32'd0);
    check_value("rst_exc", 32'(s_exc), 32'd0);
    check_value("rst_req", 32'(s_req), 32'd0);
    check_value("rst_count", 32'(s_count), 32'd0);
    check_value("rst_drop", 32'(s_drop), 32'd0);

    // Streaming
    issue_q = '{30'h040, 30'h041, 30'h042};
    mem_en  = 1'b1;
    step();
    check_value("stream_first_req", 32'(s_req), 32'd1);
    step();
    step();
    check_value("stream_handoff_valid", 32'(s_valid), 32'd1);
    check_value("stream_handoff_pc", 32'(s_pc), 32'h040);
    repeat (6) step();
    check_value("stream_delivered", 32'(n_deliv), 32'd3);

    // Backpressure
    issue_q  = '{30'h040, 30'h041, 30'h042};
    de_stall = 1'b1;
    repeat (5) step();
    check_value("bp_req", 32'(s_req), 32'd0);
    check_value("bp_stall", 32'(s_stall), 32'd1);
    check_value("bp_count", 32'(s_count), 32'd2);
    de_stall = 1'b0;
    repeat (8) step();
    check_value("bp_delivered", 32'(n_deliv), 32'd6);
    check_value("bp_drained", 32'(exp_q.size()), 32'd0);

    // Redirect with two fetches in flight
    mem_en  = 1'b0;
    issue_q = '{30'h040, 30'h041};
    step();
    step();
    issue_q  = '{30'h080};
    de_setpc = 1'b1;
    step();
    check_value("kill_req", 32'(s_req), 32'd0);
    check_value("kill_valid", 32'(s_valid), 32'd0);
    de_setpc = 1'b0;
    step();
    check_value("redir_drop", 32'(s_drop), 32'd2);
    check_value("redir_count", 32'(s_count), 32'd0);
    check_value("redir_req_blocked", 32'(s_req), 32'd0);
    mem_en = 1'b1;
    repeat (8) step();
    check_value("redir_delivered", 32'(n_deliv), 32'd7);
    check_value("redir_drop_end", 32'(s_drop), 32'd0);

    // Kill and response in the same cycle
    issue_q  = '{30'h050, 30'h051};
    de_stall = 1'b1;
    step();
    step();
    issue_q.delete();
    de_setpc = 1'b1;
    step();
    check_value("killrv_valid", 32'(s_valid), 32'd0);
    check_value("killrv_count", 32'(s_count), 32'd2);
    de_setpc = 1'b0;
    step();
    check_value("killrv_count_after", 32'(s_count), 32'd0);
    check_value("killrv_drop_after", 32'(s_drop), 32'd0);

    // Access fault
    issue_q = '{c_fault_wa};
    step();
    step();
    step();
    check_value("fault_valid", 32'(s_valid), 32'd1);
    check_value("fault_exc", 32'(s_exc), 32'd1);
    check_value("fault_insn", s_insn, 32'd0);
    check_value("fault_pc", 32'(s_pc), 32'h0C0);
    de_stall = 1'b0;
    repeat (3) step();
    check_value("fault_delivered", 32'(n_deliv), 32'd8);

    // Reset mid-operation with an entry queued and a response owed
    mem_en  = 1'b0;
    issue_q = '{30'h060};
    step();
    de_setpc = 1'b1;
    step();
    de_setpc = 1'b0;
    issue_q  = '{30'h061};
    step();
    step();
    check_value("prerst_count", 32'(s_count), 32'd1);
    check_value("prerst_drop", 32'(s_drop), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check_value("midrst_valid", 32'(s_valid), 32'd0);
    check_value("midrst_pc", 32'(s_pc), 32'd0);
    check_value("midrst_insn", s_insn, 32'd0);
    check_value("midrst_count", 32'(s_count), 32'd0);
    check_value("midrst_drop", 32'(s_drop), 32'd0);
    mem_en  = 1'b1;
    issue_q = '{30'h040};
    repeat (5) step();
    check_value("final_delivered", 32'(n_deliv), 32'd9);
    check_value("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
